traffic_lights_multi: RTL and testbench
=======================================

Name: traffic_lights_multi

Overview:
- N-channel intersection controller, successor of the single-head traffic light block.
- Drives one red/yellow/green head per approach and grants right-of-way round-robin, one approach at a time.
- Per-approach green times, a runtime channel-enable mask and an all-red clearance interval are programmable.
- Keeps the shared command set: on, off, manual yellow blink, and timing setup.

Parameters:
N_CH, 4, number of approaches (2..16)
CLK_HZ, 2000, clk_i frequency in Hz; ms-to-cycles factor = CLK_HZ/1000
BLINK_HALF_PERIOD_MS, 3, blink half-period (>0); HALF = BLINK_HALF_PERIOD_MS*CLK_HZ/1000 cycles
BLINK_GREEN_TIME_TICK, 4, full green-blink periods before yellow (>0)
RED_YELLOW_MS, 7, red+yellow duration (>=0; 0 skips the phase)

Ports:
clk_i  in  1  clock
srst_i  in  1  reset, asynchronous, active-high
cmd_type_i  in  3  command code
cmd_valid_i  in  1  command strobe, one-cycle, no backpressure
cmd_ch_i  in  $clog2(N_CH)  target channel for cmd 3
cmd_data_i  in  16  command payload (cycles, or mask for cmd 6)
red_o  out  N_CH  red lamp per channel
yellow_o  out  N_CH  yellow lamp per channel
green_o  out  N_CH  green lamp per channel
active_ch_o  out  $clog2(N_CH)  channel currently holding right-of-way

Behaviour:
- Reset (async assert, released on clock edge):
  - state = ALL_RED, cur_ch = N_CH-1.
  - green_time[i] = 10, yellow_time = 10, all_red_time = 10, en_mask = all ones.
  - Outputs: red_o = all ones, yellow_o = 0, green_o = 0, active_ch_o = N_CH-1.
- Outputs decode registered state combinationally; no extra latency. Every channel other than cur_ch shows red only, in every running state.
- FSM states: ALL_RED, RED_YELLOW, GREEN, GREEN_BLINK, YELLOW, YELLOW_MANUAL, OFF.
- Phase timer: 16-bit, cleared on every state change. A programmed length of 0 is treated as 1.
- ALL_RED:
  - Hold all_red_time cycles.
  - Then cur_ch = next enabled channel strictly after cur_ch, round-robin wrap.
  - Go to RED_YELLOW, or GREEN if RED_YELLOW_MS = 0.
  - Single enabled channel: reselects itself. en_mask = 0: stay in ALL_RED indefinitely.
- RED_YELLOW: red and yellow on for cur_ch for RED_YELLOW_MS*CLK_HZ/1000 cycles, then GREEN.
- GREEN: green on for green_time[cur_ch] cycles, then GREEN_BLINK.
- GREEN_BLINK:
  - Each period is HALF cycles off, then HALF cycles on.
  - Exactly 2*HALF*BLINK_GREEN_TIME_TICK cycles, then YELLOW.
  - No dark cycle at the boundary.
- YELLOW: yellow on for yellow_time cycles, then ALL_RED.
- YELLOW_MANUAL:
  - All channels blink yellow in phase, starting ON for HALF cycles, then OFF for HALF cycles, repeating.
  - Red and green off.
- OFF: all lamps off.
- Commands (one per cycle, sampled when cmd_valid_i = 1):
  - 0 ON: from OFF or YELLOW_MANUAL go to ALL_RED with cur_ch = N_CH-1, so channel 0 (or the first enabled channel after it) is served next. Ignored while running.
  - 1 OFF: any state -> OFF on the next edge.
  - 2 MANUAL: any state -> YELLOW_MANUAL. Blink phase restarts ON, including when already in YELLOW_MANUAL.
  - 3 set green_time[cmd_ch_i] = cmd_data_i. cmd_ch_i >= N_CH is ignored.
  - 4 set all_red_time.
  - 5 set yellow_time.
  - 6 set en_mask = cmd_data_i[N_CH-1:0].
  - Commands 3..6 take effect only in YELLOW_MANUAL and are ignored elsewhere.
  - Command 7 is ignored.
- Reset asserted mid-phase: immediate return to reset values; any partially issued command is discarded.

Decomposition:
- Package traffic_lights_multi_pkg:
  - cmd_t enum (CMD_ON=0 .. CMD_MASK=6)
  - state_t enum
  - function ms_to_cycles(ms, clk_hz)
  - default-time constants (10)
- Sub-module blink_gen:
  - Half-period counter plus phase toggle.
  - Inputs: run, restart, start_level. Output: level.
  - One instance shared by GREEN_BLINK (start_level = 0) and YELLOW_MANUAL (start_level = 1).
- Round-robin next-enabled search is a function in the main module.

Test Plan:
- Defaults, N_CH=4, HALF=6, red/yellow phase = 14 cycles, reset released: ALL_RED 10 -> ch0 RY 14 -> G 10 -> GB 48 (off 6 / on 6, x4) -> Y 10 -> ALL_RED 10 -> ch1 RY. Other heads red throughout; active_ch_o tracks cur_ch.
- In manual: cmd 3 (ch2, 25), cmd 6 (mask 4'b0101), cmd 0 -> only ch0 and ch2 are served; ch2 green lasts 25 cycles; ch1 and ch3 stay red.
- cmd 3 issued during GREEN -> ignored; next ch green still 10 cycles.
- cmd 2 mid-GREEN_BLINK -> next cycle all yellow_o = 4'b1111 for 6 cycles, then 0 for 6; second cmd 2 restarts the ON phase.
- cmd 1 in any state -> all lamps 0 next cycle; cmd 4 in OFF is ignored; cmd 0 -> ALL_RED with red_o = 4'b1111.
- Mask 0 set, then cmd 0 -> permanent all-red. Async reset asserted mid-YELLOW -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/traffic_lights_multi_pkg.sv
// ---------------------------------------------------------------------------
// traffic_lights_multi_pkg
// Shared types and constants for the multi-approach traffic light controller.
//   cmd_t          : command codes carried on cmd_type_i
//   state_t        : controller FSM states
//   ms_to_cycles() : converts a millisecond duration into clk_i cycles
//   DEFAULT_*      : phase lengths loaded at reset (in clk_i cycles)
// ---------------------------------------------------------------------------
package traffic_lights_multi_pkg;

  typedef enum logic [2:0] {
    CMD_ON      = 3'd0,
    CMD_OFF     = 3'd1,
    CMD_MANUAL  = 3'd2,
    CMD_GREEN   = 3'd3,
    CMD_ALL_RED = 3'd4,
    CMD_YELLOW  = 3'd5,
    CMD_MASK    = 3'd6
  } cmd_t;

  typedef enum logic [2:0] {
    ST_ALL_RED,
    ST_RED_YELLOW,
    ST_GREEN,
    ST_GREEN_BLINK,
    ST_YELLOW,
    ST_YELLOW_MANUAL,
    ST_OFF
  } state_t;

  localparam logic [15:0] DEFAULT_GREEN_TIME   = 16'd10;
  localparam logic [15:0] DEFAULT_YELLOW_TIME  = 16'd10;
  localparam logic [15:0] DEFAULT_ALL_RED_TIME = 16'd10;

  // Integer conversion done at elaboration time; the product is taken
  // before the division so sub-kHz clocks still round sensibly.
  function automatic int ms_to_cycles(input int ms, input int clk_hz);
    return (ms * clk_hz) / 1000;
  endfunction

endpackage

// File: rtl/traffic_lights_multi_blink.sv
// ---------------------------------------------------------------------------
// blink_gen
// Half-period counter with a phase toggle, used for both the green blink
// before yellow and the manual yellow blink.
//   clk_i       : clock
//   srst_i      : asynchronous active-high reset
//   run         : advance the half-period counter
//   restart     : force the phase back to start_level with a fresh count
//   start_level : level presented while idle or right after a restart
//   level       : current blink level
// ---------------------------------------------------------------------------
module blink_gen #(
  parameter int HALF = 6
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic run,
  input  logic restart,
  input  logic start_level,
  output logic level
);

  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  logic [15:0] half_cnt;

  // While not running the generator is parked at start_level with a zero
  // count, so the first cycle of a blink phase already shows the wanted
  // level and lasts a full half-period.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      half_cnt <= '0;
      level    <= 1'b0;
    end else if (restart || !run) begin
      half_cnt <= '0;
      level    <= start_level;
    end else if (half_cnt >= HALF_LAST) begin
      half_cnt <= '0;
      level    <= ~level;
    end else begin
      half_cnt <= half_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/traffic_lights_multi.sv
// ---------------------------------------------------------------------------
// traffic_lights_multi
// N-approach intersection controller. Grants right-of-way round-robin to one
// enabled approach at a time, sequencing red+yellow, green, green blink and
// yellow, with an all-red clearance between approaches. Also supports off,
// manual yellow blink and runtime timing/mask programming.
//   clk_i       : clock
//   srst_i      : asynchronous active-high reset
//   cmd_type_i  : command code (cmd_t)
//   cmd_valid_i : one-cycle command strobe
//   cmd_ch_i    : approach addressed by the green-time command
//   cmd_data_i  : command payload (cycles, or enable mask)
//   red_o       : red lamp per approach
//   yellow_o    : yellow lamp per approach
//   green_o     : green lamp per approach
//   active_ch_o : approach currently holding right-of-way
// ---------------------------------------------------------------------------
module traffic_lights_multi
  import traffic_lights_multi_pkg::*;
#(
  parameter int N_CH                  = 4,
  parameter int CLK_HZ                = 2000,
  parameter int BLINK_HALF_PERIOD_MS  = 3,
  parameter int BLINK_GREEN_TIME_TICK = 4,
  parameter int RED_YELLOW_MS         = 7
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic [2:0]              cmd_type_i,
  input  logic                    cmd_valid_i,
  input  logic [$clog2(N_CH)-1:0] cmd_ch_i,
  input  logic [15:0]             cmd_data_i,
  output logic [N_CH-1:0]         red_o,
  output logic [N_CH-1:0]         yellow_o,
  output logic [N_CH-1:0]         green_o,
  output logic [$clog2(N_CH)-1:0] active_ch_o
);

  localparam int CH_W       = $clog2(N_CH);
  localparam int HALF       = ms_to_cycles(BLINK_HALF_PERIOD_MS, CLK_HZ);
  localparam int RY_CYCLES  = ms_to_cycles(RED_YELLOW_MS, CLK_HZ);
  localparam logic [15:0] RY_LEN = 16'(RY_CYCLES);
  localparam logic [15:0] GB_LEN = 16'(2 * HALF * BLINK_GREEN_TIME_TICK);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t            state;
  logic [CH_W-1:0]   cur_ch;
  logic [15:0]       timer;
  logic [15:0]       green_time [N_CH];
  logic [15:0]       yellow_time;
  logic [15:0]       all_red_time;
  logic [N_CH-1:0]   en_mask;

  logic [15:0]       phase_len;
  logic              phase_done;
  logic [CH_W:0]     next_sel;
  logic              next_found;
  logic [CH_W-1:0]   next_ch;
  logic              cmd_manual;
  logic              blink_run;
  logic              blink_start;
  logic              blink_level;

  // Round-robin search for the first enabled approach strictly after cur.
  // Walking k from far to near lets the nearest hit overwrite the result;
  // k = N_CH lands back on cur so a single enabled approach reselects itself.
  // Returns {found, channel}.
  function automatic logic [CH_W:0] next_enabled(input logic [CH_W-1:0] cur,
                                                 input logic [N_CH-1:0] mask);
    logic [CH_W:0]   res;
    logic [CH_W-1:0] idx;
    res = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = CH_W'((int'(cur) + k) % N_CH);
      if (mask[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign next_sel   = next_enabled(cur_ch, en_mask);
  assign next_found = next_sel[CH_W];
  assign next_ch    = next_sel[CH_W-1:0];

  // Length of the phase we are currently in; a programmed zero still
  // occupies one cycle so the sequence can never stall on it.
  always_comb begin
    phase_len = 16'd1;
    case (state)
      ST_ALL_RED:     phase_len = all_red_time;
      ST_RED_YELLOW:  phase_len = RY_LEN;
      ST_GREEN:       phase_len = green_time[cur_ch];
      ST_GREEN_BLINK: phase_len = GB_LEN;
      ST_YELLOW:      phase_len = yellow_time;
      default:        phase_len = 16'd1;
    endcase
    if (phase_len == 16'd0) begin
      phase_len = 16'd1;
    end
  end

  assign phase_done = (timer >= (phase_len - 16'd1));

  // The blink generator is shared: it parks at "off" ahead of the green
  // blink and restarts at "on" whenever a manual command arrives.
  assign cmd_manual  = cmd_valid_i && (cmd_type_i == CMD_MANUAL);
  assign blink_run   = (state == ST_GREEN_BLINK) || (state == ST_YELLOW_MANUAL);
  assign blink_start = cmd_manual || (state == ST_YELLOW_MANUAL);

  blink_gen #(
    .HALF(HALF)
  ) u_blink (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .run        (blink_run),
    .restart    (cmd_manual),
    .start_level(blink_start),
    .level      (blink_level)
  );

  // Main controller. Off and manual override everything; on only restarts
  // a stopped controller; programming is accepted only in manual blink so
  // timing never changes under a running approach.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state        <= ST_ALL_RED;
      cur_ch       <= LAST_CH;
      timer        <= '0;
      yellow_time  <= DEFAULT_YELLOW_TIME;
      all_red_time <= DEFAULT_ALL_RED_TIME;
      en_mask      <= '1;
      for (int i = 0; i < N_CH; i++) begin
        green_time[i] <= DEFAULT_GREEN_TIME;
      end
    end else if (cmd_valid_i && (cmd_type_i == CMD_OFF)) begin
      state <= ST_OFF;
      timer <= '0;
    end else if (cmd_manual) begin
      state <= ST_YELLOW_MANUAL;
      timer <= '0;
    end else if (cmd_valid_i && (cmd_type_i == CMD_ON) &&
                 ((state == ST_OFF) || (state == ST_YELLOW_MANUAL))) begin
      state  <= ST_ALL_RED;
      cur_ch <= LAST_CH;
      timer  <= '0;
    end else begin
      if (cmd_valid_i && (state == ST_YELLOW_MANUAL)) begin
        case (cmd_type_i)
          CMD_GREEN: begin
            if (int'(cmd_ch_i) < N_CH) begin
              green_time[cmd_ch_i] <= cmd_data_i;
            end
          end
          CMD_ALL_RED: all_red_time <= cmd_data_i;
          CMD_YELLOW:  yellow_time  <= cmd_data_i;
          CMD_MASK:    en_mask      <= cmd_data_i[N_CH-1:0];
          default:     ;
        endcase
      end

      case (state)
        ST_ALL_RED: begin
          if (phase_done) begin
            // With nothing enabled we hold here with the timer parked.
            if (next_found) begin
              cur_ch <= next_ch;
              state  <= (RY_LEN == 16'd0) ? ST_GREEN : ST_RED_YELLOW;
              timer  <= '0;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_RED_YELLOW: begin
          if (phase_done) begin
            state <= ST_GREEN;
            timer <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_GREEN: begin
          if (phase_done) begin
            state <= ST_GREEN_BLINK;
            timer <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_GREEN_BLINK: begin
          if (phase_done) begin
            state <= ST_YELLOW;
            timer <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_YELLOW: begin
          if (phase_done) begin
            state <= ST_ALL_RED;
            timer <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          timer <= '0;
        end
      endcase
    end
  end

  // Lamp decode from registered state. Every approach but cur_ch is red in
  // all running states; manual blink and off leave red dark everywhere.
  always_comb begin
    red_o    = '0;
    yellow_o = '0;
    green_o  = '0;
    case (state)
      ST_ALL_RED: begin
        red_o = '1;
      end
      ST_RED_YELLOW: begin
        red_o            = '1;
        yellow_o[cur_ch] = 1'b1;
      end
      ST_GREEN: begin
        red_o           = '1;
        red_o[cur_ch]   = 1'b0;
        green_o[cur_ch] = 1'b1;
      end
      ST_GREEN_BLINK: begin
        red_o           = '1;
        red_o[cur_ch]   = 1'b0;
        green_o[cur_ch] = blink_level;
      end
      ST_YELLOW: begin
        red_o            = '1;
        red_o[cur_ch]    = 1'b0;
        yellow_o[cur_ch] = 1'b1;
      end
      ST_YELLOW_MANUAL: begin
        yellow_o = {N_CH{blink_level}};
      end
      default: ;
    endcase
  end

  assign active_ch_o = cur_ch;

endmodule

// File: tb/tb_traffic_lights_multi.sv
// ---------------------------------------------------------------------------
// tb_traffic_lights_multi
// Directed bench for traffic_lights_multi with default parameters
// (N_CH=4, HALF=6 cycles, red+yellow 14 cycles, blink 48 cycles).
// Lamps are compared as one packed word {red, yellow, green, active_ch}.
// ---------------------------------------------------------------------------
module tb_traffic_lights_multi;

  logic        clk_i;
  logic        srst_i;
  logic [2:0]  cmd_type_i;
  logic        cmd_valid_i;
  logic [1:0]  cmd_ch_i;
  logic [15:0] cmd_data_i;
  logic [3:0]  red_o;
  logic [3:0]  yellow_o;
  logic [3:0]  green_o;
  logic [1:0]  active_ch_o;

  logic [15:0] lamps;
  int          check_count;
  int          error_count;

  traffic_lights_multi #(
    .N_CH                 (4),
    .CLK_HZ               (2000),
    .BLINK_HALF_PERIOD_MS (3),
    .BLINK_GREEN_TIME_TICK(4),
    .RED_YELLOW_MS        (7)
  ) dut (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .cmd_type_i (cmd_type_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ch_i   (cmd_ch_i),
    .cmd_data_i (cmd_data_i),
    .red_o      (red_o),
    .yellow_o   (yellow_o),
    .green_o    (green_o),
    .active_ch_o(active_ch_o)
  );

  assign lamps = {2'b00, red_o, yellow_o, green_o, active_ch_o};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Expected lamp word for red/yellow/green masks and the active approach.
  function automatic logic [15:0] lv(input logic [3:0] r, input logic [3:0] y,
                                     input logic [3:0] g, input logic [1:0] ch);
    return {2'b00, r, y, g, ch};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are captured on the
  // next one; outputs are therefore also sampled 1 unit after the edge.
  task automatic applyStimulus(input logic [2:0] t, input logic [1:0] ch,
                               input logic [15:0] d);
    cmd_type_i  = t;
    cmd_ch_i    = ch;
    cmd_data_i  = d;
    cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    cmd_type_i  = 3'd0;
    cmd_ch_i    = 2'd0;
    cmd_data_i  = 16'd0;
  endtask

  task automatic expectFor(input string tag, input int n, input logic [15:0] exp);
    for (int i = 0; i < n; i++) begin
      checkOutput(tag, lamps, exp);
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic expectBlink(input logic [1:0] ch);
    for (int p = 0; p < 4; p++) begin
      expectFor("gblink_off", 6, lv(~onehot(ch), 4'h0, 4'h0, ch));
      expectFor("gblink_on", 6, lv(~onehot(ch), 4'h0, onehot(ch), ch));
    end
  endtask

  // Full service of one approach: red+yellow, green, blink, yellow.
  task automatic expectServe(input logic [1:0] ch, input int gtime, input int ytime);
    expectFor("red_yellow", 14, lv(4'hF, onehot(ch), 4'h0, ch));
    expectFor("green", gtime, lv(~onehot(ch), 4'h0, onehot(ch), ch));
    expectBlink(ch);
    expectFor("yellow", ytime, lv(~onehot(ch), onehot(ch), 4'h0, ch));
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    srst_i      = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_type_i  = 3'd0;
    cmd_ch_i    = 2'd0;
    cmd_data_i  = 16'd0;

    #2;
    checkOutput("reset_state", lamps, lv(4'hF, 4'h0, 4'h0, 2'd3));
    @(posedge clk_i);
    #1;
    srst_i = 1'b0;

    // Default sequence from reset: clearance, ch0 full service, ch1 next.
    expectFor("all_red_init", 10, lv(4'hF, 4'h0, 4'h0, 2'd3));
    expectServe(2'd0, 10, 10);
    expectFor("all_red_ch0", 10, lv(4'hF, 4'h0, 4'h0, 2'd0));
    expectFor("red_yellow_ch1", 14, lv(4'hF, 4'b0010, 4'h0, 2'd1));

    // Green-time write while running must be ignored.
    expectFor("green_ch1", 2, lv(4'b1101, 4'h0, 4'b0010, 2'd1));
    applyStimulus(3'd3, 2'd2, 16'd25);
    expectFor("green_ch1", 7, lv(4'b1101, 4'h0, 4'b0010, 2'd1));
    expectBlink(2'd1);
    expectFor("yellow_ch1", 10, lv(4'b1101, 4'b0010, 4'h0, 2'd1));
    expectFor("all_red_ch1", 10, lv(4'hF, 4'h0, 4'h0, 2'd1));
    expectFor("red_yellow_ch2", 14, lv(4'hF, 4'b0100, 4'h0, 2'd2));
    expectFor("green_ch2_unchanged", 10, lv(4'b1011, 4'h0, 4'b0100, 2'd2));

    // Manual blink entered mid green-blink, then restarted by a second cmd.
    expectFor("gblink_off_ch2", 6, lv(4'b1011, 4'h0, 4'h0, 2'd2));
    expectFor("gblink_on_ch2", 5, lv(4'b1011, 4'h0, 4'b0100, 2'd2));
    applyStimulus(3'd2, 2'd0, 16'd0);
    expectFor("manual_on", 6, lv(4'h0, 4'hF, 4'h0, 2'd2));
    expectFor("manual_off", 6, lv(4'h0, 4'h0, 4'h0, 2'd2));
    expectFor("manual_on2", 3, lv(4'h0, 4'hF, 4'h0, 2'd2));
    applyStimulus(3'd2, 2'd0, 16'd0);
    expectFor("manual_restart_on", 6, lv(4'h0, 4'hF, 4'h0, 2'd2));
    expectFor("manual_restart_off", 1, lv(4'h0, 4'h0, 4'h0, 2'd2));

    // Program ch2 green and mask 0101 in manual, then resume.
    applyStimulus(3'd3, 2'd2, 16'd25);
    applyStimulus(3'd6, 2'd0, 16'h0005);
    applyStimulus(3'd7, 2'd0, 16'h0003);
    applyStimulus(3'd0, 2'd0, 16'd0);
    expectFor("all_red_resume", 10, lv(4'hF, 4'h0, 4'h0, 2'd3));
    expectServe(2'd0, 10, 10);
    expectFor("all_red_mask_ch0", 10, lv(4'hF, 4'h0, 4'h0, 2'd0));
    expectServe(2'd2, 25, 10);
    expectFor("all_red_mask_ch2", 10, lv(4'hF, 4'h0, 4'h0, 2'd2));
    expectFor("red_yellow_wrap_ch0", 3, lv(4'hF, 4'b0001, 4'h0, 2'd0));

    // Off from a running state, timing write ignored while off, then on.
    applyStimulus(3'd1, 2'd0, 16'd0);
    expectFor("off", 3, lv(4'h0, 4'h0, 4'h0, 2'd0));
    applyStimulus(3'd4, 2'd0, 16'd3);
    expectFor("off_after_cmd4", 2, lv(4'h0, 4'h0, 4'h0, 2'd0));
    applyStimulus(3'd0, 2'd0, 16'd0);
    expectFor("all_red_after_on", 10, lv(4'hF, 4'h0, 4'h0, 2'd3));
    expectFor("red_yellow_after_on", 1, lv(4'hF, 4'b0001, 4'h0, 2'd0));

    // Empty mask: permanent all-red.
    applyStimulus(3'd2, 2'd0, 16'd0);
    applyStimulus(3'd6, 2'd0, 16'h0000);
    applyStimulus(3'd0, 2'd0, 16'd0);
    expectFor("all_red_mask0", 40, lv(4'hF, 4'h0, 4'h0, 2'd3));

    // Reprogram clearance and yellow, then reset asynchronously mid-yellow.
    applyStimulus(3'd2, 2'd0, 16'd0);
    applyStimulus(3'd4, 2'd0, 16'd2);
    applyStimulus(3'd5, 2'd0, 16'd20);
    applyStimulus(3'd6, 2'd0, 16'h000F);
    applyStimulus(3'd0, 2'd0, 16'd0);
    expectFor("all_red_short", 2, lv(4'hF, 4'h0, 4'h0, 2'd3));
    expectServe(2'd0, 10, 15);
    #2;
    srst_i = 1'b1;
    #1;
    checkOutput("async_reset_mid_yellow", lamps, lv(4'hF, 4'h0, 4'h0, 2'd3));
    @(posedge clk_i);
    #1;
    srst_i = 1'b0;
    checkOutput("after_reset_release", lamps, lv(4'hF, 4'h0, 4'h0, 2'd3));

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
